// File: rtl/change_event_pkg.sv
// Shared defaults and FSM encoding for the change-event watcher.
package change_event_pkg;
  localparam int W_DEF     = 2;
  localparam int DEPTH_DEF = 4;
  localparam int TSW_DEF   = 8;

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} ceq_state_e;

  // Flat width of one event record {mask, value, time}.
  function automatic int evt_width(input int w, input int tsw);
    return 2 * w + tsw;
  endfunction
endpackage

// File: rtl/change_event_fifo.sv
// Show-ahead synchronous FIFO of change events, with a tail-merge write port.
module change_event_fifo
  import change_event_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TSW   = TSW_DEF,
  localparam int EW   = 2 * W + TSW,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          tail_wr,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  typedef struct packed {
    logic [W-1:0]   mask;
    logic [W-1:0]   value;
    logic [TSW-1:0] tstamp;
  } change_evt_t;

  change_evt_t       mem_q [DEPTH];
  change_evt_t       mem_d [DEPTH];
  change_evt_t       din_s;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok, merge_ok;

  assign din_s    = change_evt_t'(din);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign head     = empty ? '0 : EW'(mem_q[rd_ptr_q]);
  assign tail_ptr = wr_ptr_q - AW'(1);

  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push_ok  = push && (!full || pop_ok);
  assign merge_ok = tail_wr && full && !pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else if (merge_ok) begin
      mem_d[tail_ptr].mask  = mem_q[tail_ptr].mask | din_s.mask;
      mem_d[tail_ptr].value = din_s.value;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/change_event_queue.sv
// Clocked change watcher: timestamps per-cycle value changes of watch into a queue.
// CHANGE_EVENT_COALESCE_EN: merge into the tail entry instead of dropping when full.
module change_event_queue
  import change_event_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TSW   = TSW_DEF,
  localparam int EW   = 2 * W + TSW,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   watch,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [W-1:0]   evt_mask,
  output logic [W-1:0]   evt_value,
  output logic [TSW-1:0] evt_time,
  output logic [CW-1:0]  count,
  output logic           overflow
);
  ceq_state_e     state_q;
  logic [W-1:0]   prev_q, prev_d, chg;
  logic [TSW-1:0] ts_q, ts_d;
  logic           overflow_q, overflow_d;
  logic           push, pop, merge, full, empty;
  logic [EW-1:0]  din, head;

  always_comb begin
    prev_d = watch;
    ts_d   = ts_q + TSW'(1);
    // PRIME only loads prev, so a nonzero watch at reset release is not an event.
    chg    = (state_q == RUN) ? (watch ^ prev_q) : '0;
    push   = |chg;
    din    = {chg, watch, ts_q};
    pop    = evt_valid && evt_ready;
`ifdef CHANGE_EVENT_COALESCE_EN
    merge      = push && full && !pop;
    overflow_d = overflow_q;
`else
    merge      = 1'b0;
    overflow_d = overflow_q | (push && full && !pop);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PRIME;
      prev_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= RUN;
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
    end
  end

  change_event_fifo #(.W(W), .DEPTH(DEPTH), .TSW(TSW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .tail_wr (merge),
    .din     (din),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign evt_valid                       = !empty;
  assign {evt_mask, evt_value, evt_time} = head;
  assign overflow                        = overflow_q;
endmodule

// File: tb/tb_change_event_queue.sv
// Directed bench for change_event_queue (default build; coalescing expectations under its macro).
module tb_change_event_queue;
  localparam int W = 2, DEPTH = 4, TSW = 8;

  logic           clk = 1'b0;
  logic           rst, evt_ready, evt_valid, overflow;
  logic [W-1:0]   watch, evt_mask, evt_value;
  logic [TSW-1:0] evt_time;
  logic [2:0]     count;
  int             errors = 0, checks = 0;

  change_event_queue #(.W(W), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .watch(watch), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_mask(evt_mask), .evt_value(evt_value), .evt_time(evt_time),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] m, input logic [31:0] v,
                          input logic [31:0] t);
    chk({tag, ".valid"}, evt_valid, 1);
    chk({tag, ".mask"}, evt_mask, m);
    chk({tag, ".value"}, evt_value, v);
    chk({tag, ".time"}, evt_time, t);
  endtask

  task automatic do_reset(input logic [W-1:0] w);
    rst = 1'b1; watch = w; evt_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // After reset: PRIME edge, then four alternating changes at ts=1..4 with no consumer.
  task automatic fill4();
    do_reset(2'b00);
    tick();
    watch = 2'b11; tick();
    watch = 2'b00; tick();
    watch = 2'b11; tick();
    watch = 2'b00; tick();
  endtask

  initial begin
    // Reset state and quiet input
    do_reset(2'b00);
    chk("rst.valid", evt_valid, 0);
    chk("rst.count", count, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.mask", evt_mask, 0);
    chk("rst.value", evt_value, 0);
    chk("rst.time", evt_time, 0);
    repeat (10) tick();
    chk("quiet.valid", evt_valid, 0);
    chk("quiet.count", count, 0);
    chk("quiet.ovf", overflow, 0);

    // Single step at ts=3 with consumer ready
    do_reset(2'b00);
    repeat (3) tick();
    watch = 2'b01; evt_ready = 1'b1;
    tick();
    chk_head("step", 2'b01, 2'b01, 3);
    chk("step.count", count, 1);
    tick();
    chk("step.gone", evt_valid, 0);
    chk("step.count0", count, 0);

    // Fill, then a fifth change with no pop
    fill4();
    chk("fill.count", count, 4);
    chk_head("fill.head", 2'b11, 2'b11, 1);
    chk("fill.ovf", overflow, 0);
    watch = 2'b11; tick();
    chk("full.count", count, 4);
    chk_head("full.head", 2'b11, 2'b11, 1);
`ifdef CHANGE_EVENT_COALESCE_EN
    chk("full.ovf", overflow, 0);
`else
    chk("full.ovf", overflow, 1);
`endif
    evt_ready = 1'b1;
    tick(); chk_head("drain.e2", 2'b11, 2'b00, 2);
    tick(); chk_head("drain.e3", 2'b11, 2'b11, 3);
`ifdef CHANGE_EVENT_COALESCE_EN
    tick(); chk_head("drain.e4", 2'b11, 2'b11, 4);
`else
    tick(); chk_head("drain.e4", 2'b11, 2'b00, 4);
`endif
    tick();
    chk("drain.valid", evt_valid, 0);
    chk("drain.count", count, 0);
`ifdef CHANGE_EVENT_COALESCE_EN
    chk("drain.ovf", overflow, 0);
`else
    chk("drain.ovf_sticky", overflow, 1);
`endif

    // Full with simultaneous pop and push
    fill4();
    watch = 2'b11; evt_ready = 1'b1;
    tick();
    chk("pp.count", count, 4);
    chk("pp.ovf", overflow, 0);
    chk_head("pp.head", 2'b11, 2'b00, 2);
    tick(); chk_head("pp.e3", 2'b11, 2'b11, 3);
    tick(); chk_head("pp.e4", 2'b11, 2'b00, 4);
    tick(); chk_head("pp.e5", 2'b11, 2'b11, 5);
    tick(); chk("pp.empty", evt_valid, 0);

    // Timestamp wrap, then reset mid-drain
    do_reset(2'b00);
    repeat (255) tick();
    watch = 2'b01; tick();
    watch = 2'b00; tick();
    chk("wrap.count", count, 2);
    chk_head("wrap.e255", 2'b01, 2'b01, 255);
    evt_ready = 1'b1; tick();
    chk_head("wrap.e0", 2'b01, 2'b00, 0);
    chk("wrap.count1", count, 1);
    do_reset(2'b11);
    chk("mid.valid", evt_valid, 0);
    chk("mid.count", count, 0);
    tick();
    tick();
    chk("prime.valid", evt_valid, 0);
    chk("prime.count", count, 0);
    chk("prime.ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
